// File: rtl/ldlt_solve_if.sv
`default_nettype none
// ============================================================================
//  Module      : ldlt_solve_if
//  Description : Bus bundle for the LDLT triangular solver. Carries the
//                valid-qualified input word stream (factor words, then b),
//                the input-ready indication and the valid-only x result
//                stream with the busy and divide-by-zero status flags.
//  Ports       : i_valid/i_data  word stream into the solver
//                i_ready         solver accepts words
//                o_valid/o_data  solution words x[0..N-1]
//                o_busy          job in progress
//                o_err           sticky divide-by-zero flag
//  Revision    : 1.0  initial release
// ============================================================================
interface ldlt_solve_if #(
  parameter int DATA_LEN = 32
) ();
  logic                i_valid;
  logic [DATA_LEN-1:0] i_data;
  logic                i_ready;
  logic                o_valid;
  logic [DATA_LEN-1:0] o_data;
  logic                o_busy;
  logic                o_err;

  modport master (
    output i_valid, i_data,
    input  i_ready, o_valid, o_data, o_busy, o_err
  );

  modport slave (
    input  i_valid, i_data,
    output i_ready, o_valid, o_data, o_busy, o_err
  );
endinterface
`default_nettype wire

// File: rtl/ldlt_solve.sv
`default_nettype none
// ============================================================================
//  Module      : ldlt_solve
//  Description : Solves A*x = b with A = L*D*L^T. Loads the column-ordered
//                L/D factor stream followed by b, then runs forward
//                substitution (L*y = b), diagonal scaling (z = y / D) and
//                back substitution (L^T*x = z) on one shared multiply-
//                accumulate datapath, and streams x[0..N-1] out.
//                Fixed-point format Q(DATA_LEN-FRACTION).FRACTION.
//  Ports       : clk, rst_n (asynchronous, active-low)
//                bus.slave : i_valid/i_data in, i_ready, o_valid/o_data,
//                            o_busy, o_err out
//  Options     : LDLT_SOLVE_SAT_EN - saturate subtraction results and
//                quotients instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module ldlt_solve #(
  parameter int DATA_LEN = 32,
  parameter int FRACTION = 16,
  parameter int N        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  ldlt_solve_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * DATA_LEN;
  localparam int AW = PW + 8;
  localparam int QW = DATA_LEN + FRACTION;
  localparam logic [IW-1:0]       LAST = IW'(N - 1);
  localparam logic [IW-1:0]       ONE  = IW'(1);
  localparam logic signed [AW-1:0] RND = {{(AW-FRACTION){1'b0}}, {FRACTION{1'b1}}};
  localparam logic [DATA_LEN-1:0] MAXV = {1'b0, {(DATA_LEN-1){1'b1}}};
  localparam logic [DATA_LEN-1:0] MINV = {1'b1, {(DATA_LEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOADF, S_LOADB, S_FWD, S_DIAG, S_BWD, S_OUT
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        i_q, i_d, c_q, c_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 o_valid_q, o_valid_d, err_q, err_d;
  logic [DATA_LEN-1:0]  o_data_q, o_data_d;

  // Factor storage: L strictly below the diagonal, D separately.
  // v_q holds b, then is overwritten in place by y, z and finally x.
  logic [DATA_LEN-1:0]  l_q [N][N];
  logic [DATA_LEN-1:0]  d_q [N];
  logic [DATA_LEN-1:0]  v_q [N];

  logic                 ready, xfer, f_we, v_we;
  logic [DATA_LEN-1:0]  v_wd;

  assign ready = (state_q == S_IDLE) || (state_q == S_LOADF) || (state_q == S_LOADB);
  assign xfer  = bus.i_valid && ready;

  // ---------------- shared multiply-accumulate ----------------
  // Back substitution walks column i_q downward from row i_q+1.
  logic [IW-1:0]        k_idx;
  logic [DATA_LEN-1:0]  mul_a, mul_b;
  logic signed [PW-1:0] mul_ax, mul_bx, prod;
  logic signed [AW-1:0] prod_x, acc_rz;
  logic [DATA_LEN-1:0]  acc_t;

  assign k_idx = i_q + c_q + ONE;

  always_comb begin
    mul_a = l_q[i_q][c_q];
    mul_b = v_q[c_q];
    if (state_q == S_BWD) begin
      mul_a = l_q[k_idx][i_q];
      mul_b = v_q[k_idx];
    end
  end

  assign mul_ax = {{DATA_LEN{mul_a[DATA_LEN-1]}}, mul_a};
  assign mul_bx = {{DATA_LEN{mul_b[DATA_LEN-1]}}, mul_b};
  assign prod   = mul_ax * mul_bx;
  assign prod_x = {{(AW-PW){prod[PW-1]}}, prod};

  // Round toward zero: bias negative sums before the arithmetic shift.
  assign acc_rz = acc_q[AW-1] ? (acc_q + RND) : acc_q;
  assign acc_t  = DATA_LEN'(acc_rz >>> FRACTION);

  // ---------------- row finish: v[i] - trunc(acc) ----------------
  logic [DATA_LEN-1:0]  v_sel, d_sel, sub_res, div_res, z_res;
  assign v_sel = v_q[i_q];
  assign d_sel = d_q[i_q];

`ifdef LDLT_SOLVE_SAT_EN
  logic [DATA_LEN:0] sub_x;
  assign sub_x   = {v_sel[DATA_LEN-1], v_sel} - {acc_t[DATA_LEN-1], acc_t};
  assign sub_res = (sub_x[DATA_LEN] != sub_x[DATA_LEN-1]) ?
                   (sub_x[DATA_LEN] ? MINV : MAXV) : sub_x[DATA_LEN-1:0];
`else
  assign sub_res = v_sel - acc_t;
`endif

  // ---------------- diagonal scaling ----------------
  logic                 d_zero;
  logic signed [QW-1:0] dvd, dvs, quo;
  assign d_zero = (d_sel == '0);
  assign dvd    = {v_sel, {FRACTION{1'b0}}};
  // Divisor forced to 1 on zero so the divider never sees x/0.
  assign dvs    = d_zero ? {{(QW-1){1'b0}}, 1'b1} : {{FRACTION{d_sel[DATA_LEN-1]}}, d_sel};
  assign quo    = dvd / dvs;

`ifdef LDLT_SOLVE_SAT_EN
  logic quo_fits;
  assign quo_fits = (quo[QW-1:DATA_LEN-1] == '0) || (quo[QW-1:DATA_LEN-1] == '1);
  assign div_res  = quo_fits ? DATA_LEN'(quo) : (quo[QW-1] ? MINV : MAXV);
`else
  assign div_res  = DATA_LEN'(quo);
`endif

  assign z_res = d_zero ? (v_sel[DATA_LEN-1] ? MINV : MAXV) : div_res;

  // ---------------- control ----------------
  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    c_d       = c_q;
    acc_d     = acc_q;
    o_valid_d = 1'b0;
    o_data_d  = o_data_q;
    err_d     = err_q;
    f_we      = 1'b0;
    v_we      = 1'b0;
    v_wd      = bus.i_data;
    case (state_q)
      S_IDLE: begin
        // (i,j) sits at (0,0) here, so the first word lands in D[0].
        if (xfer) begin
          f_we  = 1'b1;
          err_d = 1'b0;
          if (N == 1) begin
            state_d = S_LOADB;
          end else begin
            state_d = S_LOADF;
            i_d     = ONE;
          end
        end
      end
      S_LOADF: begin
        if (xfer) begin
          f_we = 1'b1;
          if (i_q == LAST) begin
            if (c_q == LAST) begin
              state_d = S_LOADB;
              i_d     = '0;
              c_d     = '0;
            end else begin
              c_d = c_q + ONE;
              i_d = c_q + ONE;
            end
          end else begin
            i_d = i_q + ONE;
          end
        end
      end
      S_LOADB: begin
        if (xfer) begin
          v_we = 1'b1;
          if (i_q == LAST) begin
            state_d = S_FWD;
            i_d     = '0;
            c_d     = '0;
            acc_d   = '0;
          end else begin
            i_d = i_q + ONE;
          end
        end
      end
      S_FWD: begin
        if (c_q == i_q) begin
          v_we  = 1'b1;
          v_wd  = sub_res;
          acc_d = '0;
          c_d   = '0;
          if (i_q == LAST) begin
            state_d = S_DIAG;
            i_d     = '0;
          end else begin
            i_d = i_q + ONE;
          end
        end else begin
          acc_d = acc_q + prod_x;
          c_d   = c_q + ONE;
        end
      end
      S_DIAG: begin
        v_we = 1'b1;
        v_wd = z_res;
        if (d_zero) err_d = 1'b1;
        if (i_q == LAST) begin
          state_d = S_BWD;
          i_d     = LAST;
          c_d     = '0;
        end else begin
          i_d = i_q + ONE;
        end
      end
      S_BWD: begin
        // Row i needs N-1-i accumulate cycles before it can finish.
        if (c_q == (LAST - i_q)) begin
          v_we  = 1'b1;
          v_wd  = sub_res;
          acc_d = '0;
          c_d   = '0;
          if (i_q == '0) begin
            state_d = S_OUT;
          end else begin
            i_d = i_q - ONE;
          end
        end else begin
          acc_d = acc_q + prod_x;
          c_d   = c_q + ONE;
        end
      end
      S_OUT: begin
        o_valid_d = 1'b1;
        o_data_d  = v_sel;
        if (i_q == LAST) begin
          state_d = S_IDLE;
          i_d     = '0;
          c_d     = '0;
        end else begin
          i_d = i_q + ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      err_q     <= err_d;
    end
  end

  // Storage arrays carry no reset; their contents are rewritten every job.
  always_ff @(posedge clk) begin
    if (f_we) begin
      if (i_q == c_q) d_q[c_q] <= bus.i_data;
      else            l_q[i_q][c_q] <= bus.i_data;
    end
    if (v_we) v_q[i_q] <= v_wd;
  end

  assign bus.i_ready = ready;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_busy  = (state_q != S_IDLE);
  assign bus.o_err   = err_q;
endmodule
`default_nettype wire

// File: tb/tb_ldlt_solve.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldlt_solve
//  Description : Scoreboard bench for ldlt_solve (N=2). Jobs are modelled
//                with plain 64-bit integer arithmetic; expected x words are
//                queued at issue and popped by an independent monitor.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ldlt_solve;
  localparam int DL   = 32;
  localparam int FR   = 16;
  localparam int N    = 2;
  localparam int LAT  = N * (N + 1) + N + 1;
  localparam int BUSY = N * (N + 1) + 2 * N;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ldlt_solve_if #(.DATA_LEN(DL)) bus ();

  ldlt_solve #(.DATA_LEN(DL), .FRACTION(FR), .N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_x_q [$];
  logic        exp_err_q [$];
  bit          exp_first_q [$];
  int          last_b_cyc = 0;
  logic        prev_err = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int fit(input longint v);
`ifdef LDLT_SOLVE_SAT_EN
    if (v > 64'sd2147483647)  return int'(32'h7FFF_FFFF);
    if (v < -64'sd2147483648) return int'(32'h8000_0000);
`endif
    return int'(v);
  endfunction

  // Sums stay within 64 bits because N is small.
  task automatic model(input int dv[N], input int lv[N][N], input int bv[N],
                       output int xv[N], output logic err);
    int y[N];
    int z[N];
    longint acc;
    err = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc = 0;
      for (int k = 0; k < i; k++) acc += longint'(lv[i][k]) * longint'(y[k]);
      y[i] = fit(longint'(bv[i]) - longint'(int'(acc / 65536)));
    end
    for (int i = 0; i < N; i++) begin
      if (dv[i] == 0) begin
        z[i] = (y[i] >= 0) ? int'(32'h7FFF_FFFF) : int'(32'h8000_0000);
        err  = 1'b1;
      end else begin
        z[i] = fit((longint'(y[i]) * 65536) / longint'(dv[i]));
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      acc = 0;
      for (int k = i + 1; k < N; k++) acc += longint'(lv[k][i]) * longint'(xv[k]);
      xv[i] = fit(longint'(z[i]) - longint'(int'(acc / 65536)));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.o_valid) begin
      if (exp_x_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_o_valid: got data 0x%08h, expected no output", bus.o_data);
      end else begin
        logic [31:0] ex;
        logic        ee;
        bit          ef;
        ex = exp_x_q.pop_front();
        ee = exp_err_q.pop_front();
        ef = exp_first_q.pop_front();
        chk("x_word", bus.o_data, ex);
        chk("o_err_at_out", 32'(bus.o_err), 32'(ee));
        if (ef) chk("latency", 32'(cyc - last_b_cyc), 32'(LAT));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input int w, input bit gaps);
    int n;
    if (gaps) begin
      n = $urandom_range(0, 3);
      repeat (n) begin
        bus.i_valid = 1'b0;
        bus.i_data  = $urandom;
        @(negedge clk);
      end
    end
    bus.i_valid = 1'b1;
    bus.i_data  = w;
    n = 0;
    while (!bus.i_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.i_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got i_ready=0 for %0d cycles, expected 1", n);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_job(input int dv[N], input int lv[N][N], input int bv[N],
                         input bit gaps, input bit hold, input bit rst_mid);
    int   xv[N];
    logic err;
    bit   first;
    model(dv, lv, bv, xv, err);
    chk("o_err_sticky", 32'(bus.o_err), 32'(prev_err));
    for (int i = 0; i < N; i++) begin
      exp_x_q.push_back(xv[i]);
      exp_err_q.push_back(err);
      exp_first_q.push_back(i == 0);
    end
    first = 1'b1;
    for (int j = 0; j < N; j++) begin
      for (int i = j; i < N; i++) begin
        send((i == j) ? dv[j] : lv[i][j], gaps);
        if (first) chk("o_err_cleared", 32'(bus.o_err), 32'd0);
        first = 1'b0;
      end
    end
    for (int k = 0; k < N; k++) send(bv[k], gaps);
    last_b_cyc = cyc;
    if (rst_mid) begin
      repeat (N * (N + 1) / 2 + N + 1) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_o_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_o_data", bus.o_data, 32'd0);
      chk("rst_o_busy", 32'(bus.o_busy), 32'd0);
      chk("rst_o_err", 32'(bus.o_err), 32'd0);
      chk("rst_i_ready", 32'(bus.i_ready), 32'd1);
      exp_x_q.delete();
      exp_err_q.delete();
      exp_first_q.delete();
      bus.i_valid = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      prev_err = 1'b0;
      return;
    end
    for (int b = 0; b < BUSY; b++) begin
      bus.i_valid = hold;
      bus.i_data  = $urandom;
      chk("busy_i_ready", 32'(bus.i_ready), 32'd0);
      chk("busy_o_busy", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("outputs_pending", 32'(exp_x_q.size()), 32'd0);
    prev_err = err;
  endtask

  task automatic job2(input int d0, input int l10, input int d1, input int b0, input int b1,
                      input bit gaps, input bit hold, input bit rst_mid);
    int dv[N];
    int lv[N][N];
    int bv[N];
    dv[0] = d0;  dv[1] = d1;
    lv[0][0] = 0; lv[0][1] = 0; lv[1][0] = l10; lv[1][1] = 0;
    bv[0] = b0;  bv[1] = b1;
    run_job(dv, lv, bv, gaps, hold, rst_mid);
  endtask

  function automatic int rnd_small(input int range_q16);
    return int'($urandom_range(0, 2 * range_q16)) - range_q16;
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  dv[N];
    int  lv[N][N];
    int  bv[N];
    bit  wide;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_o_valid", 32'(bus.o_valid), 32'd0);
    chk("reset_o_data", bus.o_data, 32'd0);
    chk("reset_o_busy", 32'(bus.o_busy), 32'd0);
    chk("reset_o_err", 32'(bus.o_err), 32'd0);
    chk("reset_i_ready", 32'(bus.i_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Worked example: x = (0.0, 2.0).
    job2(32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 0, 0);
    // Identity factors: negative and fractional values pass straight through.
    job2(32'h0001_0000, 0, 32'h0001_0000, int'(32'hFFFF_0000), 32'h0001_8000, 0, 0, 0);
    // Zero pivot: z[0] pins to the positive limit and o_err is raised.
    job2(0, 0, 32'h0001_0000, 32'h0001_0000, 0, 0, 0, 0);
    // Same worked example with input gaps and i_valid held through the busy phase.
    job2(32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1, 1, 0);
    // Reset in the middle of back substitution, then a clean job.
    job2(32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 0, 1);
    job2(32'h0002_0000, 32'h0000_8000, 32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 0, 0, 0);
    // Large L10: y1 = 1 - 32767 stays representable.
    job2(32'h0001_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 0, 0, 0);
    // Large L10 with b1 at the negative limit: y1 overflows (wrap or saturate).
    job2(32'h0001_0000, 32'h7FFF_0000, 32'h0001_0000, 32'h0001_0000, int'(32'h8000_0000), 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      wide = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) == 0) dv[i] = 0;
        else begin
          dv[i] = int'($urandom_range(32'h4000, 32'h4_0000));
          if ($urandom_range(0, 1) == 1) dv[i] = -dv[i];
        end
        bv[i] = wide ? int'($urandom) : rnd_small(64 * 65536);
        for (int j = 0; j < N; j++) lv[i][j] = wide ? int'($urandom) : rnd_small(2 * 65536);
      end
      run_job(dv, lv, bv, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
